// File: rtl/ccc_cfg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ccc_cfg_pkg                                                        |
// | Shared types and widths for the CCC APB reconfiguration block.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package ccc_cfg_pkg;

    localparam int c_ADDR_W = 6;
    localparam int c_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_ACCESS    = 3'd2,
        ST_PLL_RST   = 3'd3,
        ST_LOCK_WAIT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_READ   = 2'b00,
        OP_WRITE  = 2'b01,
        OP_COMMIT = 2'b10,
        OP_RSVD   = 2'b11
    } req_op_t;

    // Only the write encoding drives PWRITE; the reserved code behaves as a read.
    function automatic logic op_is_write(input logic [1:0] op);
        return op == OP_WRITE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ccc_sync2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ccc_sync2                                                          |
// | Two-flop synchronizer, asynchronous active-low reset.              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ccc_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/ccc_apb_reconfig.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ccc_apb_reconfig                                                   |
// | Request-driven APB initiator and PLL reset/relock sequencer for    |
// | a CCC. Optional lock timeout: define CCC_LOCK_TIMEOUT_EN.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ccc_apb_reconfig
    import ccc_cfg_pkg::*;
#(
    parameter int ARST_CYCLES  = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                PCLK,
    input  logic                PRESET_N,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [c_ADDR_W-1:0] req_addr,
    input  logic [c_DATA_W-1:0] req_wdata,
    output logic                rsp_valid,
    output logic [c_DATA_W-1:0] rsp_rdata,
    output logic                rsp_err,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [c_ADDR_W-1:0] PADDR,
    output logic [c_DATA_W-1:0] PWDATA,
    input  logic [c_DATA_W-1:0] PRDATA,
    output logic                PLL_ARST_N,
    input  logic                LOCK
);

    if (ARST_CYCLES < 1 || ARST_CYCLES > 255 ||
        LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 65535) begin : g_bad_params
        $error("ccc_apb_reconfig: ARST_CYCLES or LOCK_TIMEOUT out of range");
    end

    localparam logic [7:0] c_ARST_LAST = 8'(ARST_CYCLES - 1);

    state_t              r_state;
    logic                r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [c_ADDR_W-1:0] r_paddr;
    logic [c_DATA_W-1:0] r_pwdata;
    logic                r_rsp_valid;
    logic [c_DATA_W-1:0] r_rsp_rdata;
    logic                r_pll_arst_n;
    logic [7:0]          r_arst_cnt;
    logic                w_lock_sync;

`ifdef CCC_LOCK_TIMEOUT_EN
    localparam logic [15:0] c_TMO_LAST = 16'(LOCK_TIMEOUT - 1);
    logic        r_rsp_err;
    logic [15:0] r_tmo_cnt;
`endif

    ccc_sync2 u_lock_sync (
        .clk   (PCLK),
        .rst_n (PRESET_N),
        .i_d   (LOCK),
        .o_q   (w_lock_sync)
    );

    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            r_state      <= ST_IDLE;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_pll_arst_n <= 1'b1;
            r_arst_cnt   <= 8'd0;
`ifdef CCC_LOCK_TIMEOUT_EN
            r_rsp_err    <= 1'b0;
            r_tmo_cnt    <= 16'd0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_op == OP_COMMIT) begin
                            r_state      <= ST_PLL_RST;
                            r_pll_arst_n <= 1'b0;
                            r_arst_cnt   <= 8'd0;
                        end else begin
                            r_state  <= ST_SETUP;
                            r_psel   <= 1'b1;
                            r_pwrite <= op_is_write(req_op);
                            r_paddr  <= req_addr;
                            r_pwdata <= req_wdata;
                        end
                    end
                end
                ST_SETUP: begin
                    r_state   <= ST_ACCESS;
                    r_penable <= 1'b1;
                end
                ST_ACCESS: begin
                    // No PREADY on the CCC port: every transfer completes here.
                    r_state     <= ST_IDLE;
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_pwrite    <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
`ifdef CCC_LOCK_TIMEOUT_EN
                    r_rsp_err   <= 1'b0;
`endif
                end
                ST_PLL_RST: begin
                    if (r_arst_cnt == c_ARST_LAST) begin
                        r_state      <= ST_LOCK_WAIT;
                        r_pll_arst_n <= 1'b1;
`ifdef CCC_LOCK_TIMEOUT_EN
                        r_tmo_cnt    <= 16'd0;
`endif
                    end else begin
                        r_arst_cnt <= r_arst_cnt + 8'd1;
                    end
                end
                ST_LOCK_WAIT: begin
                    if (w_lock_sync) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
`ifdef CCC_LOCK_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
                    end else if (r_tmo_cnt == c_TMO_LAST) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                    end else if (r_tmo_cnt != 16'hFFFF) begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign PSEL       = r_psel;
    assign PENABLE    = r_penable;
    assign PWRITE     = r_pwrite;
    assign PADDR      = r_paddr;
    assign PWDATA     = r_pwdata;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign PLL_ARST_N = r_pll_arst_n;
`ifdef CCC_LOCK_TIMEOUT_EN
    assign rsp_err    = r_rsp_err;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule
`default_nettype wire
